// File: rtl/io_strobe_seq_pkg.sv
// io_strobe_pkg: shared types and helpers for the I/O strobe sequencer.
//   state_t : sequencer state encoding (IDLE, SETUP, ACTIVE, HOLD, DONE), 3 bits
//   cnt_w() : width of the phase counter, wide enough for the longest phase
package io_strobe_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACTIVE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Counter holds values up to max(phase length) - 1, but sizing for the
  // full maximum keeps the loaded values representable for any setting.
  function automatic int cnt_w(input int setup_cyc, input int active_cyc,
                               input int hold_cyc);
    int m;
    int w;
    m = setup_cyc;
    if (active_cyc > m) m = active_cyc;
    if (hold_cyc > m) m = hold_cyc;
    w = $clog2(m + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/io_strobe_seq_if.sv
// io_strobe_seq_if: CPU request/ack handshake plus decoder drive signals.
//   req, addr         : CPU request level and address (master -> slave)
//   ack, hit, busy    : completion pulse, window-hit pulse, activity flag
//   dec_en_n, dec_sel : active-low decoder enable and 2-bit select
//   wait_n            : only with IO_STROBE_WAIT_EN defined; stretches ACTIVE while 0
interface io_strobe_seq_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic              hit;
  logic              busy;
  logic              dec_en_n;
  logic [1:0]        dec_sel;
`ifdef IO_STROBE_WAIT_EN
  logic              wait_n;

  modport master (output req, addr, wait_n,
                  input  ack, hit, busy, dec_en_n, dec_sel);
  modport slave  (input  req, addr, wait_n,
                  output ack, hit, busy, dec_en_n, dec_sel);
`else
  modport master (output req, addr,
                  input  ack, hit, busy, dec_en_n, dec_sel);
  modport slave  (input  req, addr,
                  output ack, hit, busy, dec_en_n, dec_sel);
`endif
endinterface

// File: rtl/io_strobe_seq_cnt.sv
// io_strobe_cnt: loadable down-counter timing each sequencer phase.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   dec      : count down by one, unless frozen or already zero
//   freeze   : hold the current value
//   zero     : count == 0
module io_strobe_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         freeze,
  output logic         zero
);

  logic [W-1:0] count;

  // Saturates at zero so the count can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !freeze && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/io_strobe_seq.sv
// io_strobe_seq: bus-cycle strobe sequencer feeding a 2-to-4 inverted decoder.
// A CPU request inside the BASE/MASK window latches the select bits and runs
// SETUP -> ACTIVE -> HOLD -> DONE, giving a fixed-width active-low enable
// pulse; a request outside the window is acknowledged at once with hit=0.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : io_strobe_seq_if.slave (req/addr in; ack/hit/busy/dec_en_n/dec_sel out)
// Optional feature: define IO_STROBE_WAIT_EN to add bus.wait_n, which freezes
// the ACTIVE phase while low.
module io_strobe_seq
  import io_strobe_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE     = 16'h3C00,
  parameter logic [ADDR_W-1:0] MASK     = 16'hFFF0,
  parameter int              SEL_LSB    = 0,
  parameter int              SETUP_CYC  = 1,
  parameter int              ACTIVE_CYC = 2,
  parameter int              HOLD_CYC   = 1
) (
  input logic          clk,
  input logic          rst,
  io_strobe_seq_if.slave bus
);

  localparam int CW = cnt_w(SETUP_CYC, ACTIVE_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] ACTIVE_LD = CW'(ACTIVE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t      state;
  state_t      state_nxt;
  logic        win_hit;
  logic        miss_ack;
  logic        cnt_load;
  logic [CW-1:0] cnt_val;
  logic        cnt_dec;
  logic        cnt_freeze;
  logic        cnt_zero;

  logic        ack_q;
  logic        hit_q;
  logic        busy_q;
  logic        dec_en_n_q;
  logic [1:0]  dec_sel_q;

  assign win_hit = ((bus.addr & MASK) == (BASE & MASK));

`ifdef IO_STROBE_WAIT_EN
  assign cnt_freeze = (state == ACTIVE) && !bus.wait_n;
`else
  assign cnt_freeze = 1'b0;
`endif

  io_strobe_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .freeze   (cnt_freeze),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; each phase loads the counter with its length minus one
  // on entry and leaves once the counter has reached zero.
  always_comb begin
    state_nxt = state;
    miss_ack  = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (win_hit) begin
            state_nxt = SETUP;
            cnt_load  = 1'b1;
            cnt_val   = SETUP_LD;
          end else begin
            miss_ack  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nxt = ACTIVE;
          cnt_load  = 1'b1;
          cnt_val   = ACTIVE_LD;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt_freeze) begin
          state_nxt = ACTIVE;
        end else if (cnt_zero) begin
          if (HOLD_CYC == 0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = HOLD;
            cnt_load  = 1'b1;
            cnt_val   = HOLD_LD;
          end
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = DONE;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so every decoder-facing
  // signal comes straight from a flop and cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      busy_q     <= 1'b0;
      dec_en_n_q <= 1'b1;
      dec_sel_q  <= 2'b00;
    end else begin
      ack_q      <= miss_ack || (state_nxt == DONE);
      hit_q      <= (state_nxt == DONE);
      busy_q     <= (state_nxt != IDLE);
      dec_en_n_q <= (state_nxt != ACTIVE);
      if ((state == IDLE) && bus.req && win_hit) begin
        dec_sel_q <= bus.addr[SEL_LSB+1:SEL_LSB];
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.hit      = hit_q;
  assign bus.busy     = busy_q;
  assign bus.dec_en_n = dec_en_n_q;
  assign bus.dec_sel  = dec_sel_q;

endmodule
